rr_variability_monitor: RTL

//   Next-generation beat-irregularity detector on the 1 kHz clk_div domain (1 tick = 1 ms).

---
 rtl/rr_variability_monitor.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/rr_variability_monitor.sv
// rr_variability_monitor
// Beat-irregularity detector running on the 1 kHz clk_div domain (1 tick = 1 ms).
// Keeps a circular history of the last DEPTH RR intervals with a running sum, flags
// a beat as irregular when it jumps away from the previous RR (successive test) or
// from the window mean (mean test), tracks irregular beats across the window and
// drives a WARMUP/MONITOR/AF state machine that raises a sustained AF alert.
// Every test looks at the history as it stood before the new beat is inserted.

module rr_variability_monitor #(
  parameter  int RR_W        = 12,
  parameter  int DEPTH       = 8,
  parameter  int DIFF_THRESH = 200,
  parameter  int MEAN_THRESH = 150,
  parameter  int AF_ENTER    = 4,
  parameter  int AF_EXIT     = 1,
  parameter  int CNT_W       = 16,
  localparam int LOG2D       = $clog2(DEPTH)
) (
  input  logic               clk_div,
  input  logic               rst_n,
  input  logic [RR_W-1:0]    rr_interval_ms,
  input  logic               new_rr_pulse,
  input  logic               stats_clr,
  output logic               irreg_flag,
  output logic [CNT_W-1:0]   irreg_count,
  output logic [LOG2D:0]     irreg_in_window,
  output logic [RR_W-1:0]    rr_mean,
  output logic               mean_valid,
  output logic               af_alert,
  output logic [CNT_W-1:0]   af_episodes
);

  // Sum of DEPTH values of RR_W bits each cannot exceed RR_W+LOG2D bits.
  localparam int SUM_W = RR_W + LOG2D;

  localparam logic [RR_W-1:0] DIFF_T    = RR_W'(DIFF_THRESH);
  localparam logic [RR_W-1:0] MEAN_T    = RR_W'(MEAN_THRESH);
  localparam logic [LOG2D:0]  FILL_FULL = (LOG2D + 1)'(DEPTH);
  localparam logic [LOG2D:0]  WIN_ENTER = (LOG2D + 1)'(AF_ENTER);
  localparam logic [LOG2D:0]  WIN_EXIT  = (LOG2D + 1)'(AF_EXIT);

  typedef enum logic [1:0] {
    ST_WARMUP  = 2'd0,
    ST_MONITOR = 2'd1,
    ST_AF      = 2'd2
  } state_t;

  // History and statistics
  logic [RR_W-1:0]  r_buf [DEPTH];
  logic [LOG2D-1:0] r_wr_ptr;
  logic [LOG2D:0]   r_fill;
  logic [SUM_W-1:0] r_sum;
  logic [DEPTH-1:0] r_hist;
  state_t           r_state;

  // Registered outputs
  logic             r_flag;
  logic [CNT_W-1:0] r_count;
  logic [LOG2D:0]   r_win;
  logic [RR_W-1:0]  r_mean;
  logic             r_mean_valid;
  logic             r_af;
  logic [CNT_W-1:0] r_episodes;

  // Decision path (all derived from the pre-insertion state)
  logic             w_accept;
  logic             w_full;
  logic [RR_W-1:0]  w_prev;
  logic [RR_W-1:0]  w_oldest;
  logic [RR_W-1:0]  w_mean_cur;
  logic [RR_W-1:0]  w_dev_prev;
  logic [RR_W-1:0]  w_dev_mean;
  logic             w_succ_hit;
  logic             w_mean_hit;
  logic             w_irreg;
  logic [SUM_W-1:0] w_sum_next;
  logic [LOG2D:0]   w_fill_next;
  logic [LOG2D:0]   w_win_next;
  logic [RR_W-1:0]  w_mean_next;

  // A zero interval is treated as "no measurement"; a clear drops a coincident beat.
  assign w_accept = new_rr_pulse && (rr_interval_ms != '0) && !stats_clr;
  assign w_full   = (r_fill == FILL_FULL);

  // The slot just behind the write pointer holds the last stored RR; the slot at the
  // write pointer holds the oldest one, which is only meaningful once the window is full.
  assign w_prev     = r_buf[r_wr_ptr - LOG2D'(1)];
  assign w_oldest   = w_full ? r_buf[r_wr_ptr] : '0;
  assign w_mean_cur = RR_W'(r_sum >> LOG2D);

  assign w_dev_prev = (rr_interval_ms >= w_prev)     ? (rr_interval_ms - w_prev)
                                                     : (w_prev - rr_interval_ms);
  assign w_dev_mean = (rr_interval_ms >= w_mean_cur) ? (rr_interval_ms - w_mean_cur)
                                                     : (w_mean_cur - rr_interval_ms);

  assign w_succ_hit = (r_fill != '0) && (w_dev_prev > DIFF_T);
  assign w_mean_hit = w_full && (w_dev_mean > MEAN_T);
  assign w_irreg    = w_succ_hit || w_mean_hit;

  assign w_sum_next  = r_sum + SUM_W'(rr_interval_ms) - SUM_W'(w_oldest);
  assign w_fill_next = w_full ? r_fill : (r_fill + 1'b1);

  // The bit leaving the shift register is always 0 until DEPTH beats have been shifted in.
  assign w_win_next  = r_win + (LOG2D + 1)'(w_irreg) - (LOG2D + 1)'(r_hist[DEPTH-1]);
  assign w_mean_next = (w_fill_next == FILL_FULL) ? RR_W'(w_sum_next >> LOG2D) : '0;

  // Accept beats, update history/statistics and step the rhythm state machine.
  always_ff @(posedge clk_div) begin
    if (!rst_n || stats_clr) begin
      // NOTE: the RR buffer is a handful of flops and is cleared here on purpose, so
      // nothing from before a reset or clear can ever leak back in as a "previous" RR.
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
      r_wr_ptr     <= '0;
      r_fill       <= '0;
      r_sum        <= '0;
      r_hist       <= '0;
      r_state      <= ST_WARMUP;
      r_flag       <= 1'b0;
      r_count      <= '0;
      r_win        <= '0;
      r_mean       <= '0;
      r_mean_valid <= 1'b0;
      r_af         <= 1'b0;
      r_episodes   <= '0;
    end else begin
      r_flag <= 1'b0;
      if (w_accept) begin
        r_buf[r_wr_ptr] <= rr_interval_ms;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
        r_fill          <= w_fill_next;
        r_sum           <= w_sum_next;
        r_hist          <= {r_hist[DEPTH-2:0], w_irreg};
        r_win           <= w_win_next;
        r_mean          <= w_mean_next;
        r_flag          <= w_irreg;
        if (w_irreg && (r_count != '1)) begin
          r_count <= r_count + 1'b1;
        end

        case (r_state)
          ST_WARMUP: begin
            // Filling the window only arms monitoring; AF can be entered from the next beat.
            if (w_fill_next == FILL_FULL) begin
              r_state      <= ST_MONITOR;
              r_mean_valid <= 1'b1;
            end
          end
          ST_MONITOR: begin
            if (w_win_next >= WIN_ENTER) begin
              r_state <= ST_AF;
              r_af    <= 1'b1;
              if (r_episodes != '1) begin
                r_episodes <= r_episodes + 1'b1;
              end
            end
          end
          ST_AF: begin
            if (w_win_next <= WIN_EXIT) begin
              r_state <= ST_MONITOR;
              r_af    <= 1'b0;
            end
          end
          default: begin
            r_state      <= ST_WARMUP;
            r_mean_valid <= 1'b0;
            r_af         <= 1'b0;
          end
        endcase
      end
    end
  end

  assign irreg_flag      = r_flag;
  assign irreg_count     = r_count;
  assign irreg_in_window = r_win;
  assign rr_mean         = r_mean;
  assign mean_valid      = r_mean_valid;
  assign af_alert        = r_af;
  assign af_episodes     = r_episodes;

endmodule
